// File: rtl/mem_test_host.sv
// mem_test_host
//   Memory test host that takes write / read / fill / burst-read commands over
//   a valid-ready command channel and drives the datapath test muxes to
//   access memory directly while the CPU is held. Read words come back over a
//   valid-ready response channel.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_op                    00 write, 01 read, 10 fill, 11 burst read
//   cmd_addr, cmd_data        start word address, write/fill data
//   cmd_len                   burst/fill word count minus 1
//   rsp_valid / rsp_ready     response handshake
//   rsp_data, rsp_addr        read word and its address
//   test                      steers datapath address/data muxes to ext_*
//   test_we                   memory write strobe
//   TestMem                   capture enable of the datapath TestMemout reg
//   ext_addr, ext_data        memory address {zeros, word addr} and data
//   TestMemout                captured memory word (valid cycle after TestMem)
//   cpu_hold                  stalls the CPU while a command is in progress
module mem_test_host #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [15:0]       cmd_data,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [15:0]       rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              test,
   output logic              test_we,
   output logic              TestMem,
   output logic [15:0]       ext_addr,
   output logic [15:0]       ext_data,
   input  logic [15:0]       TestMemout,
   output logic              cpu_hold
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_CAP, RD_RSP} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [15:0]       r_rsp_data;
   logic [ADDR_W-1:0] r_rsp_addr;
   logic              r_test;
   logic              r_test_we;
   logic              r_TestMem;
   logic [15:0]       r_ext_addr;
   logic [15:0]       r_ext_data;
   logic              r_cpu_hold;

   logic [ADDR_W-1:0] w_addr_inc;
   logic [ADDR_W-1:0] w_cnt_dec;
   logic              w_last;

   // Address arithmetic wraps naturally at 2^ADDR_W.
   assign w_addr_inc = r_addr + ADDR_W'(1);
   assign w_cnt_dec  = r_cnt - ADDR_W'(1);
   assign w_last     = (r_cnt == '0);

   function automatic logic [15:0] f_zext(input logic [ADDR_W-1:0] a);
      logic [15:0] v;
      v            = '0;
      v[ADDR_W-1:0] = a;
      return v;
   endfunction

   // All outputs are registered: each branch sets the values that belong to
   // the state being entered, so outputs line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_addr  <= '0;
         r_test      <= 1'b0;
         r_test_we   <= 1'b0;
         r_TestMem   <= 1'b0;
         r_ext_addr  <= '0;
         r_ext_data  <= '0;
         r_cpu_hold  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Ready rises one edge after reset release, then stays up
               // until a command is taken.
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  // Single write/read use a count of 0; fill/burst use len.
                  r_cnt       <= cmd_op[1] ? cmd_len : '0;
                  r_test      <= 1'b1;
                  r_cpu_hold  <= 1'b1;
                  r_ext_addr  <= f_zext(cmd_addr);
                  if (!cmd_op[0]) begin
                     r_state    <= WRITE;
                     r_test_we  <= 1'b1;
                     r_ext_data <= cmd_data;
                  end else begin
                     r_state    <= RD_ADDR;
                     r_TestMem  <= 1'b1;
                     r_ext_data <= '0;
                  end
               end
            end

            WRITE: begin
               if (w_last) begin
                  r_state     <= IDLE;
                  r_cmd_ready <= 1'b1;
                  r_test      <= 1'b0;
                  r_test_we   <= 1'b0;
                  r_cpu_hold  <= 1'b0;
                  r_ext_addr  <= '0;
                  r_ext_data  <= '0;
               end else begin
                  r_addr     <= w_addr_inc;
                  r_cnt      <= w_cnt_dec;
                  r_ext_addr <= f_zext(w_addr_inc);
               end
            end

            RD_ADDR: begin
               r_state   <= RD_CAP;
               r_TestMem <= 1'b0;
            end

            RD_CAP: begin
               // TestMemout now holds the word captured during RD_ADDR.
               r_state     <= RD_RSP;
               r_rsp_data  <= TestMemout;
               r_rsp_addr  <= r_addr;
               r_rsp_valid <= 1'b1;
            end

            RD_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_last) begin
                     r_state     <= IDLE;
                     r_cmd_ready <= 1'b1;
                     r_test      <= 1'b0;
                     r_cpu_hold  <= 1'b0;
                     r_ext_addr  <= '0;
                  end else begin
                     r_state    <= RD_ADDR;
                     r_addr     <= w_addr_inc;
                     r_cnt      <= w_cnt_dec;
                     r_ext_addr <= f_zext(w_addr_inc);
                     r_TestMem  <= 1'b1;
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_addr  = r_rsp_addr;
   assign test      = r_test;
   assign test_we   = r_test_we;
   assign TestMem   = r_TestMem;
   assign ext_addr  = r_ext_addr;
   assign ext_data  = r_ext_data;
   assign cpu_hold  = r_cpu_hold;

endmodule
